program_sequencer: RTL and testbench
====================================

Name: program_sequencer

Overview:
- Fetch/sequencing end of the instruction interface: owns the program counter (ROM address) and the instruction register.
- Supplies the 8-bit instruction byte that the control decoder consumes, and reacts to the decoder's ROM-read, load-IR and jump strobes.
- Adds run/halt control and an executed-instruction counter for bring-up on the nic8 datapath.

Parameters:
- HALT_OPCODE, 8'h3F, instruction byte that stops the machine once loaded into IR (source 7 / dest 7, otherwise a no-op).
- COUNT_W, 16, width of the executed-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- dataBus  in  8  shared data bus value this cycle (ROM/RAM/A/X/E as selected by the decoder).
- assertBarRom  in  1  active-low: ROM drives the bus this cycle (ROM byte consumed).
- loadIRBar  in  1  active-low: load IR from dataBus at this edge.
- doJump  in  1  active-high: load PC from dataBus at this edge.
- run  in  1  level; high allows execution, low requests halt at next fetch boundary.
- ir  out  8  current instruction byte to the control decoder.
- pc  out  8  ROM address.
- stall  out  1  high while halted; the clock gate downstream suppresses load/trigger strobes.
- halted  out  1  high in HALT state.
- instrCount  out  COUNT_W  number of non-fetch instructions executed; saturates.

Behaviour:
- Reset values: pc=0x00, ir=0x00 (fetch: ROM->IR), instrCount=0, halted=0, stall=0, state=RUN. Reset has priority over every other input.
- States: RUN, HALT (plus STEP under the optional feature).
- RUN, per rising edge:
  - PC:
    - doJump=1 -> pc<=dataBus. Jump overrides the increment.
    - else assertBarRom=0 -> pc<=pc+1, wrapping 0xFF->0x00.
    - else hold.
  - IR:
    - loadIRBar=0 -> ir<=dataBus.
    - else ir<=0x00, so each instruction is followed by a fetch.
  - Counter: ir!=0x00 at the edge -> instrCount+1, saturating at all-ones. The fetch cycle is not counted.
  - Simultaneous doJump and loadIRBar=0: both load dataBus (pc and ir get the same byte).
- Halt entry (RUN->HALT):
  - (a) the byte loaded into IR equals HALT_OPCODE. IR holds HALT_OPCODE and pc holds its post-fetch value. The halt instruction itself is not counted.
  - (b) run=0 at an edge where ir==0x00 (fetch boundary). The fetch is suppressed: pc and ir unchanged.
  - run=0 during a non-fetch instruction: that instruction completes, then halt occurs at the following fetch boundary.
- HALT:
  - stall=1, halted=1.
  - All strobe inputs ignored; pc, ir and instrCount frozen.
- HALT->RUN:
  - Requires run=1.
  - If ir==HALT_OPCODE, ir<=0x00 on exit (resume with a fetch at the current pc).
  - stall drops in the same cycle as the state change (registered, one edge after run rises).
- Latency: pc, ir and instrCount are registered outputs, updated one edge after their strobes. halted and stall are registered.
- Reset mid-instruction or mid-halt returns immediately to the reset values.

Optional Feature:
- Macro: PROGRAM_SEQUENCER_STEP_EN.
- With the macro, extra ports are present:
  - stepReq  in  1
  - stepAck  out  1, reset 0
- Single-step handshake:
  - In HALT, stepReq rising (registered edge detect) enters STEP with stall=0.
  - STEP executes exactly one fetch plus one instruction (two edges), then returns to HALT. An immediate halt opcode counts as the instruction.
  - stepAck=1 is held from the return to HALT until stepReq=0; it then clears on the next edge.
  - A new step is not accepted while stepAck=1.
  - run=1 takes priority over stepReq.
- Without the macro: no stepReq/stepAck ports; HALT exits only via run.

Test Plan:
- Reset release with ROM[0]=0x12 (ROM->A), run=1 -> edge1: ir=0x12, pc=1; edge2: ir=0x00, pc=2 (ROM immediate consumed), instrCount=1.
- Jump: ir holds a jump with doJump=1, dataBus=0x40 and ROM source asserted -> pc=0x40 (not pc+1), next ir=0x00.
- Wrap: pc=0xFF with assertBarRom=0 -> pc=0x00, no stall.
- Halt opcode: ROM byte 0x3F fetched at pc=5 -> halted=1, stall=1, ir=0x3F, pc=6, instrCount unchanged. Toggling strobes for 10 cycles leaves state frozen. run stays 1 throughout; dropping run to 0 and raising it back to 1 -> ir=0x00, fetch resumes at pc=6.
- run=0 asserted during a non-fetch instruction -> instruction completes, halted=1 at the next fetch boundary with pc unchanged. Reset while halted -> pc=0, ir=0, instrCount=0, halted=0.
- STEP_EN build: halted at pc=6, pulse stepReq -> exactly one counted instruction, then halted=1 and stepAck=1. stepAck clears one edge after stepReq=0. A second stepReq held high without dropping gives no extra step.

Source files
------------

// File: rtl/program_sequencer.sv
// Fetch/sequencing block for the nic8 datapath: program counter, instruction register,
// run/halt control and executed-instruction counter. Optional single-step via PROGRAM_SEQUENCER_STEP_EN.

module program_sequencer #(
    parameter logic [7:0] HALT_OPCODE = 8'h3F,
    parameter int         COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         dataBus,
    input  logic               assertBarRom,
    input  logic               loadIRBar,
    input  logic               doJump,
    input  logic               run,
`ifdef PROGRAM_SEQUENCER_STEP_EN
    input  logic               stepReq,
    output logic               stepAck,
`endif
    output logic [7:0]         ir,
    output logic [7:0]         pc,
    output logic               stall,
    output logic               halted,
    output logic [COUNT_W-1:0] instrCount
);

    // state   | meaning
    // RUN     | normal fetch/execute
    // HALT    | frozen; strobes ignored, stall asserted
    // STEP    | one fetch plus one instruction, then back to HALT
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         pc_q, pc_d;
    logic [7:0]         ir_q, ir_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               run_q, run_d;

    logic [7:0]         exec_pc;
    logic [7:0]         exec_ir;
    logic [COUNT_W-1:0] exec_cnt;
    logic               halt_load;

`ifdef PROGRAM_SEQUENCER_STEP_EN
    logic               step_req_q, step_req_d;
    logic               step_ack_q, step_ack_d;
    logic               step_phase_q, step_phase_d;
`endif

    // What a single executing edge would produce; shared by RUN and STEP.
    always_comb begin
        exec_pc   = pc_q;
        exec_ir   = 8'h00;
        exec_cnt  = cnt_q;
        halt_load = 1'b0;
        if (doJump) begin
            exec_pc = dataBus;
        end else if (!assertBarRom) begin
            exec_pc = pc_q + 8'd1;
        end
        if (!loadIRBar) begin
            exec_ir   = dataBus;
            halt_load = (dataBus == HALT_OPCODE);
        end
        if ((ir_q != 8'h00) && (cnt_q != {COUNT_W{1'b1}})) begin
            exec_cnt = cnt_q + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        run_d   = run;
`ifdef PROGRAM_SEQUENCER_STEP_EN
        step_req_d   = stepReq;
        step_ack_d   = step_ack_q && stepReq;
        step_phase_d = step_phase_q;
`endif
        case (state_q)
            ST_RUN: begin
                if (!run && (ir_q == 8'h00)) begin
                    state_d = ST_HALT;
                end else begin
                    pc_d  = exec_pc;
                    ir_d  = exec_ir;
                    cnt_d = exec_cnt;
                    if (halt_load) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                // Leaving HALT needs a fresh rise of run, so a halt opcode holds even with run high.
                if (run && !run_q) begin
                    state_d = ST_RUN;
                    if (ir_q == HALT_OPCODE) begin
                        ir_d = 8'h00;
                    end
                end
`ifdef PROGRAM_SEQUENCER_STEP_EN
                else if (stepReq && !step_req_q && !step_ack_q) begin
                    state_d      = ST_STEP;
                    step_phase_d = 1'b0;
                    if (ir_q == HALT_OPCODE) begin
                        ir_d = 8'h00;
                    end
                end
`endif
            end
`ifdef PROGRAM_SEQUENCER_STEP_EN
            ST_STEP: begin
                pc_d  = exec_pc;
                ir_d  = exec_ir;
                cnt_d = exec_cnt;
                if (halt_load || step_phase_q) begin
                    state_d    = ST_HALT;
                    step_ack_d = 1'b1;
                end else begin
                    step_phase_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= 8'h00;
            ir_q    <= 8'h00;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
        end
    end

`ifdef PROGRAM_SEQUENCER_STEP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            step_req_q   <= 1'b0;
            step_ack_q   <= 1'b0;
            step_phase_q <= 1'b0;
        end else begin
            step_req_q   <= step_req_d;
            step_ack_q   <= step_ack_d;
            step_phase_q <= step_phase_d;
        end
    end

    assign stepAck = step_ack_q;
`endif

    assign ir         = ir_q;
    assign pc         = pc_q;
    assign instrCount = cnt_q;
    assign halted     = (state_q == ST_HALT);
    assign stall      = (state_q == ST_HALT);

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer (default build): fetch, jump, wrap, halt opcode,
// run-driven halt and reset while halted.

module tb_program_sequencer;

    logic        clk;
    logic        reset;
    logic [7:0]  dataBus;
    logic        assertBarRom;
    logic        loadIRBar;
    logic        doJump;
    logic        run;
    logic [7:0]  ir;
    logic [7:0]  pc;
    logic        stall;
    logic        halted;
    logic [15:0] instrCount;

    int n_cmp  = 0;
    int n_fail = 0;

    program_sequencer #(.HALT_OPCODE(8'h3F), .COUNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .dataBus      (dataBus),
        .assertBarRom (assertBarRom),
        .loadIRBar    (loadIRBar),
        .doJump       (doJump),
        .run          (run),
        .ir           (ir),
        .pc           (pc),
        .stall        (stall),
        .halted       (halted),
        .instrCount   (instrCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] d, input logic rom_b, input logic ld_b, input logic jmp);
        dataBus      = d;
        assertBarRom = rom_b;
        loadIRBar    = ld_b;
        doJump       = jmp;
    endtask

    task automatic check_all(input string tag, input logic [7:0] e_pc, input logic [7:0] e_ir,
                             input logic [15:0] e_cnt, input logic e_halt);
        check({tag, ".pc"}, {24'd0, pc}, {24'd0, e_pc});
        check({tag, ".ir"}, {24'd0, ir}, {24'd0, e_ir});
        check({tag, ".cnt"}, {16'd0, instrCount}, {16'd0, e_cnt});
        check({tag, ".halted"}, {31'd0, halted}, {31'd0, e_halt});
        check({tag, ".stall"}, {31'd0, stall}, {31'd0, e_halt});
    endtask

    initial begin
        reset = 1'b1;
        run   = 1'b1;
        drive(8'hA5, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        check_all("reset", 8'h00, 8'h00, 16'd0, 1'b0);

        // Fetch ROM[0]=0x12 then consume its immediate
        reset = 1'b0;
        drive(8'h12, 1'b0, 1'b0, 1'b0);
        tick();
        check_all("fetch0", 8'h01, 8'h12, 16'd0, 1'b0);
        drive(8'h55, 1'b0, 1'b1, 1'b0);
        tick();
        check_all("imm0", 8'h02, 8'h00, 16'd1, 1'b0);

        // Jump to 0x40 with ROM source asserted
        drive(8'h20, 1'b0, 1'b0, 1'b0);
        tick();
        check_all("fetch_jmp", 8'h03, 8'h20, 16'd1, 1'b0);
        drive(8'h40, 1'b0, 1'b1, 1'b1);
        tick();
        check_all("jmp40", 8'h40, 8'h00, 16'd2, 1'b0);

        // Jump to 0xFF, then wrap on a ROM fetch
        drive(8'h20, 1'b0, 1'b0, 1'b0);
        tick();
        check_all("fetch_jmp2", 8'h41, 8'h20, 16'd2, 1'b0);
        drive(8'hFF, 1'b0, 1'b1, 1'b1);
        tick();
        check_all("jmpFF", 8'hFF, 8'h00, 16'd3, 1'b0);
        drive(8'h12, 1'b0, 1'b0, 1'b0);
        tick();
        check_all("wrap", 8'h00, 8'h12, 16'd3, 1'b0);
        drive(8'h77, 1'b1, 1'b1, 1'b0);
        tick();
        check_all("no_rom_hold", 8'h00, 8'h00, 16'd4, 1'b0);

        // Simultaneous jump and IR load take the same byte
        drive(8'h20, 1'b0, 1'b0, 1'b0);
        tick();
        check_all("fetch_jmp3", 8'h01, 8'h20, 16'd4, 1'b0);
        drive(8'h05, 1'b1, 1'b0, 1'b1);
        tick();
        check_all("jmp_and_ld", 8'h05, 8'h05, 16'd5, 1'b0);
        drive(8'h00, 1'b1, 1'b1, 1'b0);
        tick();
        check_all("exec05", 8'h05, 8'h00, 16'd6, 1'b0);

        // Halt opcode fetched at pc=5
        drive(8'h3F, 1'b0, 1'b0, 1'b0);
        tick();
        check_all("halt_op", 8'h06, 8'h3F, 16'd6, 1'b1);
        for (int i = 0; i < 10; i++) begin
            drive(8'(8'h11 * i + 8'h03), 1'(i % 2), 1'((i / 2) % 2), 1'((i + 1) % 2));
            tick();
            check_all("frozen", 8'h06, 8'h3F, 16'd6, 1'b1);
        end

        // Drop and raise run to resume with a fetch at pc=6
        drive(8'h00, 1'b1, 1'b1, 1'b0);
        run = 1'b0;
        tick();
        check_all("run_low_halted", 8'h06, 8'h3F, 16'd6, 1'b1);
        run = 1'b1;
        tick();
        check_all("resume", 8'h06, 8'h00, 16'd6, 1'b0);

        // run=0 during a non-fetch instruction: completes, halts at next fetch boundary
        drive(8'h12, 1'b0, 1'b0, 1'b0);
        tick();
        check_all("fetch6", 8'h07, 8'h12, 16'd6, 1'b0);
        run = 1'b0;
        drive(8'h99, 1'b0, 1'b1, 1'b0);
        tick();
        check_all("instr_completes", 8'h08, 8'h00, 16'd7, 1'b0);
        drive(8'h12, 1'b0, 1'b0, 1'b0);
        tick();
        check_all("halt_at_fetch", 8'h08, 8'h00, 16'd7, 1'b1);
        tick();
        check_all("halt_hold", 8'h08, 8'h00, 16'd7, 1'b1);

        // Reset while halted
        reset = 1'b1;
        tick();
        check_all("reset_halted", 8'h00, 8'h00, 16'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

endmodule
